// File: rtl/axis_tpg_pkg.sv
// Shared types for the AXI-Stream burst arbiter: FSM state encoding
// and the index-width helper used by the top and the round-robin picker.
package axis_tpg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Width of a source index; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_rr_select.sv
// Round-robin picker: first requesting source after last_idx, wrapping.
// Purely combinational; found is low when no source requests.
module axis_rr_select
  import axis_tpg_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  localparam int IDX_W   = idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [IDX_W-1:0]   next_idx,
  output logic               found
);

  // Scan last_idx+1 .. last_idx+NUM_SRC modulo NUM_SRC, keep the first hit.
  always_comb begin
    int j;
    j        = 0;
    next_idx = last_idx;
    found    = 1'b0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      j = int'(last_idx) + i;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!found && req[j]) begin
        found    = 1'b1;
        next_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/axis_burst_arbiter.sv
// AXI-Stream N:1 packet arbiter, round-robin, bursts capped at MAX_BURST.
// Optional m_axis_tdest output when AXIS_BURST_ARBITER_TDEST_EN is defined.
module axis_burst_arbiter
  import axis_tpg_pkg::*;
#(
  parameter  int NUM_SRC            = 4,
  parameter  int M_AXIS_TDATA_WIDTH = 32,
  parameter  int MAX_BURST          = 16,
  localparam int IDX_W              = idx_w(NUM_SRC),
  localparam int DW                 = M_AXIS_TDATA_WIDTH
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_areset,
  input  logic                  enable,
  input  logic [NUM_SRC*DW-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]    s_axis_tvalid,
  input  logic [NUM_SRC-1:0]    s_axis_tlast,
  output logic [NUM_SRC-1:0]    s_axis_tready,
  output logic [DW-1:0]         m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  busy
`ifdef AXIS_BURST_ARBITER_TDEST_EN
  ,
  output logic [IDX_W-1:0]      m_axis_tdest
`endif
);

  localparam logic [15:0] LAST_CNT = 16'(MAX_BURST - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [15:0]      beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_found;
  logic             hs;

  axis_rr_select #(
    .NUM_SRC (NUM_SRC)
  ) u_rr (
    .req      (s_axis_tvalid),
    .last_idx (grant_idx_q),
    .next_idx (rr_idx),
    .found    (rr_found)
  );

  // Datapath mux: granted source passes straight through, others held off.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state_q == GRANT) begin
      m_axis_tdata  = s_axis_tdata[int'(grant_idx_q)*DW +: DW];
      m_axis_tvalid = s_axis_tvalid[grant_idx_q];
      m_axis_tlast  = s_axis_tlast[grant_idx_q] |
                      (beat_cnt_q == LAST_CNT);
      s_axis_tready[grant_idx_q] = m_axis_tready;
    end
  end

  assign hs = m_axis_tvalid & m_axis_tready;

  // Next-state: arbitrate in IDLE, count beats and release on tlast in GRANT.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    beat_cnt_d  = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (enable && rr_found) begin
          state_d     = GRANT;
          grant_idx_d = rr_idx;
          beat_cnt_d  = '0;
        end
      end
      GRANT: begin
        if (hs) begin
          beat_cnt_d = beat_cnt_q + 16'd1;
          if (m_axis_tlast) state_d = IDLE;
        end
      end
    endcase
  end

  // State registers; reset points grant_idx at the last source so source 0 goes first.
  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      state_q     <= IDLE;
      grant_idx_q <= IDX_W'(NUM_SRC - 1);
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign grant_idx = grant_idx_q;
  assign busy      = (state_q == GRANT);

`ifdef AXIS_BURST_ARBITER_TDEST_EN
  assign m_axis_tdest = busy ? grant_idx_q : '0;
`endif

endmodule

// File: tb/tb_axis_burst_arbiter.sv
// Directed bench for axis_burst_arbiter (default build plus a MAX_BURST=4 copy).
module tb_axis_burst_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [127:0] s_tdata;
  logic [3:0]   s_tvalid, s_tlast;
  logic [3:0]   s_tready, s_tready4;
  logic [31:0]  m_tdata, m_tdata4;
  logic         m_tvalid, m_tvalid4, m_tlast, m_tlast4;
  logic         m_tready;
  logic [1:0]   grant, grant4;
  logic         busy, busy4;

  int total = 0;
  int bad   = 0;
  int k, npk, last_start, idle;
  int bn[4];
  int exp_order[5] = '{0, 1, 2, 3, 0};
  logic [3:0] r;

  always #5 clk = ~clk;

  axis_burst_arbiter u_dut (
    .m_axis_aclk   (clk),
    .m_axis_areset (rst),
    .enable        (enable),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .grant_idx     (grant),
    .busy          (busy)
  );

  axis_burst_arbiter #(.MAX_BURST(4)) u_dut4 (
    .m_axis_aclk   (clk),
    .m_axis_areset (rst),
    .enable        (enable),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready4),
    .m_axis_tdata  (m_tdata4),
    .m_axis_tvalid (m_tvalid4),
    .m_axis_tlast  (m_tlast4),
    .m_axis_tready (m_tready),
    .grant_idx     (grant4),
    .busy          (busy4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    tick();
    tick();
    rst      = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    m_tready = 1'b0;
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;

    // reset state
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_sready", s_tready, 0);
    chk("rst_grant", grant, 3);
    chk("rst_busy4", busy4, 0);
    rst = 1'b0;

    // single 3-beat packet from src0
    enable   = 1'b1;
    m_tready = 1'b1;
    s_tdata[31:0] = 32'h10;
    s_tvalid = 4'b0001;
    #1;
    chk("b_idle_mvalid", m_tvalid, 0);
    chk("b_idle_sready", s_tready, 0);
    tick();
    chk("b_busy", busy, 1);
    chk("b_grant", grant, 0);
    chk("b_d0", m_tdata, 32'h10);
    chk("b_l0", m_tlast, 0);
    chk("b_rdy", s_tready, 4'b0001);
    tick();
    s_tdata[31:0] = 32'h11;
    #1;
    chk("b_d1", m_tdata, 32'h11);
    chk("b_l1", m_tlast, 0);
    tick();
    s_tdata[31:0] = 32'h12;
    s_tlast = 4'b0001;
    #1;
    chk("b_d2", m_tdata, 32'h12);
    chk("b_l2", m_tlast, 1);
    tick();
    s_tvalid = '0;
    s_tlast  = '0;
    #1;
    chk("b_end_busy", busy, 0);

    // all sources valid, 2-beat packets: rotation and one idle cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s_tdata[i*32 +: 32] = 32'hA0 + i;
      bn[i] = 0;
    end
    s_tvalid   = 4'hF;
    npk        = 0;
    last_start = 0;
    for (int c = 0; c < 30 && npk < 5; c++) begin
      for (int i = 0; i < 4; i++) s_tlast[i] = (bn[i] == 1);
      #1;
      if (m_tvalid && m_tready && bn[grant] == 0) begin
        chk("rr_grant", grant, exp_order[npk]);
        chk("rr_data", m_tdata, 32'hA0 + exp_order[npk]);
        if (npk > 0) chk("rr_gap", c - last_start, 3);
        last_start = c;
        npk++;
      end
      r = s_tready;
      tick();
      for (int i = 0; i < 4; i++) if (r[i]) bn[i] = (bn[i] + 1) % 2;
    end
    chk("rr_pkts", npk, 5);

    // MAX_BURST=4 copy: 10-beat packet from src2 is split 4/4/2
    do_reset();
    s_tvalid = 4'b0100;
    k    = 0;
    idle = 0;
    for (int c = 0; c < 40 && k < 10; c++) begin
      s_tdata[64 +: 32] = 32'h200 + k;
      s_tlast = (k == 9) ? 4'b0100 : 4'b0000;
      #1;
      if (!busy4) idle++;
      if (s_tready4[2]) begin
        chk("mb_data", m_tdata4, 32'h200 + k);
        chk("mb_last", m_tlast4, (k == 3 || k == 7 || k == 9));
        chk("mb_grant", grant4, 2);
        k++;
      end
      tick();
    end
    chk("mb_beats", k, 10);
    chk("mb_idle", idle, 3);

    // tready toggling: no loss/duplication, src3 never sees ready
    do_reset();
    s_tvalid = 4'b1010;
    k = 0;
    for (int c = 0; c < 30 && k < 4; c++) begin
      m_tready = (c % 2 == 0);
      s_tdata[32 +: 32] = 32'h300 + k;
      s_tlast = (k == 3) ? 4'b0010 : 4'b0000;
      #1;
      chk("tg_rdy", s_tready,
          (busy && m_tready) ? 4'b0010 : 4'b0000);
      if (s_tready[1]) begin
        chk("tg_data", m_tdata, 32'h300 + k);
        chk("tg_last", m_tlast, (k == 3));
        k++;
      end
      tick();
    end
    chk("tg_beats", k, 4);
    m_tready = 1'b1;

    // enable dropped on beat 2 of a 5-beat packet
    do_reset();
    enable   = 1'b1;
    s_tvalid = 4'b0001;
    k = 0;
    for (int c = 0; c < 30 && k < 5; c++) begin
      s_tdata[31:0] = 32'h400 + k;
      s_tlast = (k == 4) ? 4'b0001 : 4'b0000;
      if (k >= 1) enable = 1'b0;
      #1;
      if (s_tready[0]) begin
        chk("en_data", m_tdata, 32'h400 + k);
        k++;
      end
      tick();
    end
    chk("en_beats", k, 5);
    s_tlast = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("en_off_busy", busy, 0);
      chk("en_off_mvalid", m_tvalid, 0);
      tick();
    end
    enable = 1'b1;
    tick();
    chk("en_on_busy", busy, 1);
    chk("en_on_grant", grant, 0);

    // reset on beat 3 abandons the packet
    do_reset();
    s_tvalid = 4'b1000;
    k = 0;
    for (int c = 0; c < 20 && k < 2; c++) begin
      s_tdata[96 +: 32] = 32'h500 + k;
      #1;
      if (s_tready[3]) k++;
      tick();
    end
    s_tdata[96 +: 32] = 32'h502;
    #1;
    chk("rs_beat3", m_tdata, 32'h502);
    rst      = 1'b1;
    s_tvalid = 4'b1110;
    tick();
    rst = 1'b0;
    #1;
    chk("rs_mvalid", m_tvalid, 0);
    chk("rs_busy", busy, 0);
    tick();
    chk("rs_busy2", busy, 1);
    chk("rs_grant", grant, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
